// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and decodes every mux select, write enable and memory request.
module multicycle_control_fsm #(
  parameter int                    OPCODE_W = 6,
  parameter logic [OPCODE_W-1:0]   OP_R     = 6'd0,
  parameter logic [OPCODE_W-1:0]   OP_ADDI  = 6'd1,
  parameter logic [OPCODE_W-1:0]   OP_LW    = 6'd2,
  parameter logic [OPCODE_W-1:0]   OP_SW    = 6'd3,
  parameter logic [OPCODE_W-1:0]   OP_BEQ   = 6'd4,
  parameter logic [OPCODE_W-1:0]   OP_J     = 6'd5,
  parameter logic [OPCODE_W-1:0]   OP_JAL   = 6'd6,
  parameter logic [OPCODE_W-1:0]   OP_HALT  = 6'd7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic [2:0]          state_o,
  output logic                instr_done,
  output logic                illegal_op
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state, state_next;
  logic   op_legal;

  always_comb begin
    op_legal = 1'b0;
    if (opcode == OP_R    || opcode == OP_ADDI || opcode == OP_LW  || opcode == OP_SW ||
        opcode == OP_BEQ  || opcode == OP_J    || opcode == OP_JAL || opcode == OP_HALT)
      op_legal = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    wb_sel     = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    state_o    = state;

    // Outputs are forced quiet while reset is high so no write enable survives its rise.
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b01;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          state_next = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          if (opcode == OP_HALT) begin
            instr_done = 1'b1;
            state_next = S_HALT;
          end else if (!op_legal) begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_EXEC;
          end
        end
        S_EXEC: begin
          state_next = S_FETCH;
          if (opcode == OP_R) begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            state_next = S_WB;
          end else if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            state_next = (opcode == OP_ADDI) ? S_WB : S_MEM;
          end else if (opcode == OP_BEQ) begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            pc_write   = zero;
            instr_done = 1'b1;
          end else if (opcode == OP_J || opcode == OP_JAL) begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            if (opcode == OP_JAL) begin
              reg_write = 1'b1;
              reg_dst   = 2'b10;
              wb_sel    = 2'b10;
            end
          end
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = (opcode == OP_LW);
          mem_write = (opcode == OP_SW);
          if (!mem_ready)            state_next = S_MEM;
          else if (opcode == OP_LW)  state_next = S_WB;
          else begin
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          reg_dst    = (opcode == OP_R)  ? 2'b01 : 2'b00;
          wb_sel     = (opcode == OP_LW) ? 2'b01 : 2'b00;
          state_next = S_FETCH;
        end
        S_HALT:  state_next = S_HALT;
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each instruction is expanded into its expected
// per-cycle output trace from the instruction-level rules, then replayed against the DUT.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic       instr_done;
    logic       illegal_op;
  } vec_t;

  localparam int W = $bits(vec_t);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, iord, mem_read, mem_write, ir_write, alu_src_a, reg_write;
  logic       instr_done, illegal_op;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, wb_sel;
  logic [2:0] state_o;
  vec_t       dut_v;

  logic [W-1:0] exp_q[$];
  logic [7:0]   stim_q[$];
  int vectors = 0;
  int miscompares = 0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .state_o(state_o), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  assign dut_v = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, wb_sel, state_o, instr_done,
                  illegal_op};

  always #5 clk = ~clk;

  task automatic check(input vec_t got, input vec_t exp, input string tag);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, W'(got), W'(exp));
    end
  endtask

  function automatic logic rz();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input vec_t v, input logic [5:0] op, input logic mr, input logic z);
    exp_q.push_back(v);
    stim_q.push_back({op, mr, z});
  endtask

  // Expected trace of one instruction: fw/mw stall cycles in FETCH/MEM, zb = ALU zero in EXEC.
  task automatic plan_instr(input logic [5:0] op, input int fw, input int mw, input logic zb);
    vec_t v;
    v = '0;
    v.mem_read  = 1'b1;
    v.alu_src_b = 2'b01;
    for (int i = 0; i < fw; i++) push(v, op, 1'b0, rz());
    v.ir_write = 1'b1;
    v.pc_write = 1'b1;
    push(v, op, 1'b1, rz());

    v = '0;
    v.state     = 3'd1;
    v.alu_src_b = 2'b11;
    if (op == 6'd7) begin
      v.instr_done = 1'b1;
      push(v, op, 1'b1, rz());
      return;
    end
    if (op > 6'd7) begin
      v.illegal_op = 1'b1;
      push(v, op, 1'b1, rz());
      return;
    end
    push(v, op, 1'b1, rz());

    v = '0;
    v.state = 3'd2;
    case (op)
      6'd0: begin v.alu_src_a = 1'b1; v.alu_op = 2'b10; end
      6'd1, 6'd2, 6'd3: begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
      6'd4: begin
        v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01;
        v.pc_write = zb; v.instr_done = 1'b1;
      end
      default: begin
        v.pc_src = 2'b10; v.pc_write = 1'b1; v.instr_done = 1'b1;
        if (op == 6'd6) begin v.reg_write = 1'b1; v.reg_dst = 2'b10; v.wb_sel = 2'b10; end
      end
    endcase
    push(v, op, 1'b1, zb);
    if (op >= 6'd4) return;

    if (op == 6'd2 || op == 6'd3) begin
      v = '0;
      v.state     = 3'd3;
      v.iord      = 1'b1;
      v.mem_read  = (op == 6'd2);
      v.mem_write = (op == 6'd3);
      for (int i = 0; i < mw; i++) push(v, op, 1'b0, rz());
      v.instr_done = (op == 6'd3);
      push(v, op, 1'b1, rz());
      if (op == 6'd3) return;
    end

    v = '0;
    v.state      = 3'd4;
    v.reg_write  = 1'b1;
    v.instr_done = 1'b1;
    v.reg_dst    = (op == 6'd0) ? 2'b01 : 2'b00;
    v.wb_sel     = (op == 6'd2) ? 2'b01 : 2'b00;
    push(v, op, 1'b1, rz());
  endtask

  // Entered and left at posedge+1; drives one planned cycle and checks it at the negedge.
  task automatic run_plan(input string tag);
    logic [7:0] s;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      opcode    = s[7:2];
      mem_ready = s[1];
      zero      = s[0];
      @(negedge clk);
      check(dut_v, exp_q.pop_front(), tag);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t v;
    logic [5:0] op;
    int sel;

    // Reset held three cycles with an R-type opcode and memory ready.
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(dut_v, '0, "reset_quiet");
    end
    @(posedge clk); #1;
    reset = 1'b0;

    plan_instr(6'd0, 0, 0, 1'b0);  run_plan("r_type");
    plan_instr(6'd2, 0, 2, 1'b0);  run_plan("lw_mem_wait");
    plan_instr(6'd4, 0, 0, 1'b1);  run_plan("beq_taken");
    plan_instr(6'd4, 0, 0, 1'b0);  run_plan("beq_not_taken");
    plan_instr(6'd6, 0, 0, 1'b0);  run_plan("jal");
    plan_instr(6'd9, 0, 0, 1'b0);  run_plan("illegal_9");
    plan_instr(6'd3, 2, 3, 1'b0);  run_plan("sw_waits");
    plan_instr(6'd5, 1, 0, 1'b1);  run_plan("j_fetch_wait");
    plan_instr(6'd1, 0, 0, 1'b0);  run_plan("addi");

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 8);
      op  = (sel < 7) ? 6'(sel) : 6'($urandom_range(8, 63));
      plan_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rz());
      run_plan("random");
    end

    // HALT then twenty idle cycles with arbitrary inputs.
    plan_instr(6'd7, 0, 0, 1'b0);
    v = '0;
    v.state = 3'd5;
    for (int i = 0; i < 20; i++) push(v, 6'd7, rz(), rz());
    run_plan("halt");

    reset = 1'b1;
    @(negedge clk);
    check(dut_v, '0, "halt_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // SW stalled in MEM, then reset asserted mid-cycle.
    opcode = 6'd3; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    v = '0;
    v.state = 3'd3; v.iord = 1'b1; v.mem_write = 1'b1;
    check(dut_v, v, "sw_mem_stall");
    #2;
    reset = 1'b1;
    #1;
    check(dut_v, '0, "async_abort");
    @(posedge clk); #1;
    reset = 1'b0;
    plan_instr(6'd3, 0, 0, 1'b0);  run_plan("after_abort_sw");
    plan_instr(6'd2, 1, 1, 1'b0);  run_plan("after_abort_lw");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
